// File: rtl/aib_pkg.sv
// Shared frame constants and FSM state type for the AIB receive deframer.
package aib_pkg;

    localparam int unsigned BEAT_W     = 40;
    localparam int unsigned MARKER_BIT = 39;
    localparam int unsigned FLAG_BIT   = 38;
    localparam int unsigned PAY_LO_W   = 38;
    localparam int unsigned PAY_HI_W   = 34;
    localparam int unsigned PAYLOAD_W  = PAY_LO_W + PAY_HI_W;

    typedef enum logic [0:0] {StHunt, StLocked} rx_state_e;

    function automatic logic [PAYLOAD_W-1:0] frame_payload(input logic [BEAT_W-1:0] beat0,
                                                            input logic [BEAT_W-1:0] beat1);
        return {beat1[PAY_HI_W-1:0], beat0[PAY_LO_W-1:0]};
    endfunction

endpackage

// File: rtl/aib_rx_fifo.sv
// Payload FIFO with count-based full/empty; a push is accepted when full if a pop
// happens in the same cycle.
module aib_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 72
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic             full_o,
    output logic [WIDTH-1:0] rdata_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    always_comb begin
        valid_o = (count_q != '0);
        full_o  = (count_q == CW'(DEPTH));
        do_pop  = pop_i && valid_o;
        do_push = push_i && (!full_o || do_pop);
        rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/aib_rx_deframer.sv
// AIB Rx deframer: locks onto two-beat frames, reassembles 72-bit words into a FIFO.
// Define AIB_RX_PARITY_EN to enable even-parity checking and the o_par_err flag.
module aib_rx_deframer
    import aib_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LOCK_PAIRS = 4,
    parameter int unsigned MISS_MAX   = 3
) (
    input  logic                 i_aib_clk,
    input  logic                 i_rst,
    input  logic [19:0]          i_rx_data0,
    input  logic [19:0]          i_rx_data1,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic [PAYLOAD_W-1:0] o_rx_data,
    output logic                 o_locked,
    output logic                 o_ovf,
    output logic                 o_par_err,
    input  logic                 i_clr_err
);

    localparam int unsigned GOOD_W = $clog2(LOCK_PAIRS + 1);
    localparam int unsigned MISS_W = $clog2(MISS_MAX + 1);

    rx_state_e          state_q;
    logic               phase_q;
    logic [BEAT_W-1:0]  beat_q, beat0_q;
    logic [GOOD_W-1:0]  good_cnt_q;
    logic [MISS_W-1:0]  miss_cnt_q;
    logic               ovf_q;

    logic                 marker, frame_ok, frame_end, par_ok, push, pop, ovf_set;
    logic                 fifo_valid, fifo_full;
    logic [PAYLOAD_W-1:0] payload;

    always_comb begin
        marker    = beat_q[MARKER_BIT];
        frame_ok  = beat0_q[MARKER_BIT] && !marker;
        payload   = frame_payload(beat0_q, beat_q);
`ifdef AIB_RX_PARITY_EN
        par_ok    = !(^payload ^ beat_q[FLAG_BIT]);
`else
        par_ok    = 1'b1;
`endif
        frame_end = (state_q == StLocked) && phase_q;
        push      = frame_end && frame_ok && beat0_q[FLAG_BIT] && par_ok;
        pop       = fifo_valid && i_rx_ready;
        ovf_set   = push && fifo_full && !pop;
    end

    always_ff @(posedge i_aib_clk) begin
        if (i_rst) begin
            state_q    <= StHunt;
            phase_q    <= 1'b0;
            beat_q     <= '0;
            beat0_q    <= '0;
            good_cnt_q <= '0;
            miss_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            beat_q <= {i_rx_data1, i_rx_data0};
            if (ovf_set)        ovf_q <= 1'b1;
            else if (i_clr_err) ovf_q <= 1'b0;
            unique case (state_q)
                StHunt: begin
                    if (!phase_q) begin
                        if (marker) begin
                            beat0_q <= beat_q;
                            phase_q <= 1'b1;
                        end else begin
                            good_cnt_q <= '0;
                        end
                    end else if (!marker) begin
                        phase_q <= 1'b0;
                        if (good_cnt_q == GOOD_W'(LOCK_PAIRS - 1)) begin
                            state_q    <= StLocked;
                            good_cnt_q <= '0;
                            miss_cnt_q <= '0;
                        end else begin
                            good_cnt_q <= good_cnt_q + 1'b1;
                        end
                    end else begin
                        // Second marker-1 beat in a row: it becomes the new beat0 candidate.
                        good_cnt_q <= '0;
                        beat0_q    <= beat_q;
                    end
                end
                StLocked: begin
                    phase_q <= !phase_q;
                    if (!phase_q) begin
                        beat0_q <= beat_q;
                    end else if (frame_ok) begin
                        miss_cnt_q <= '0;
                    end else if (miss_cnt_q == MISS_W'(MISS_MAX - 1)) begin
                        state_q    <= StHunt;
                        miss_cnt_q <= '0;
                        good_cnt_q <= '0;
                    end else begin
                        miss_cnt_q <= miss_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef AIB_RX_PARITY_EN
    logic par_err_q;

    always_ff @(posedge i_aib_clk) begin
        if (i_rst) begin
            par_err_q <= 1'b0;
        end else if (frame_end && frame_ok && beat0_q[FLAG_BIT] && !par_ok) begin
            par_err_q <= 1'b1;
        end else if (i_clr_err) begin
            par_err_q <= 1'b0;
        end
    end

    assign o_par_err = par_err_q;

    logic unused_rsvd;
    assign unused_rsvd = ^beat_q[37:34];
`else
    assign o_par_err = 1'b0;

    logic unused_rsvd;
    assign unused_rsvd = ^{beat_q[FLAG_BIT], beat_q[37:34]};
`endif

    aib_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAYLOAD_W)
    ) u_fifo (
        .clk_i   (i_aib_clk),
        .rst_i   (i_rst),
        .push_i  (push),
        .wdata_i (payload),
        .pop_i   (pop),
        .valid_o (fifo_valid),
        .full_o  (fifo_full),
        .rdata_o (o_rx_data)
    );

    assign o_rx_valid = fifo_valid;
    assign o_locked   = (state_q == StLocked);
    assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_aib_rx_deframer.sv
// Directed bench for aib_rx_deframer: expected words queued at issue, checked by a monitor.
module tb_aib_rx_deframer;

`ifdef AIB_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] d0 = '0, d1 = '0;
    logic        ready = 1'b1;
    logic        clr = 1'b0;
    logic        rx_valid, locked, ovf, par_err;
    logic [71:0] rx_data;

    int total = 0;
    int bad = 0;
    logic [71:0] exp_q[$];

    aib_rx_deframer dut (
        .i_aib_clk  (clk),
        .i_rst      (rst),
        .i_rx_data0 (d0),
        .i_rx_data1 (d1),
        .o_rx_valid (rx_valid),
        .i_rx_ready (ready),
        .o_rx_data  (rx_data),
        .o_locked   (locked),
        .o_ovf      (ovf),
        .o_par_err  (par_err),
        .i_clr_err  (clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [39:0] beat0_of(input logic [71:0] p, input logic v);
        return {1'b1, v, p[37:0]};
    endfunction

    function automatic logic [39:0] beat1_of(input logic [71:0] p, input logic par);
        return {1'b0, par, 4'b1010, p[71:38]};
    endfunction

    task automatic send_beat(input logic [39:0] b);
        @(posedge clk);
        #1;
        {d1, d0} = b;
    endtask

    // Parity is computed on the clean payload; flip >= 0 corrupts one bit afterwards.
    task automatic send_frame(input logic [71:0] p, input logic v, input logic wr, input int flip);
        logic        par;
        logic [71:0] q;
        par = ^p;
        q   = p;
        if (flip >= 0) q[flip] = ~q[flip];
        send_beat(beat0_of(q, v));
        send_beat(beat1_of(q, par));
        if (wr) exp_q.push_back(q);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_frame('0, 1'b0, 1'b0, -1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 72'(rx_valid), 72'(0));
        check({tag, "_data"}, rx_data, 72'(0));
        check({tag, "_locked"}, 72'(locked), 72'(0));
        check({tag, "_ovf"}, 72'(ovf), 72'(0));
        check({tag, "_par_err"}, 72'(par_err), 72'(0));
    endtask

    // Monitor: every accepted head word must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && rx_valid && ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got %0h want none", rx_data);
            end else begin
                logic [71:0] e;
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    bad++;
                    $display("FAIL sb_data: got %0h want %0h", rx_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [71:0] word;
        logic [71:0] ovf_words [6];
        ovf_words = '{72'h11_1111_1111_1111_1111, 72'h22_2222_2222_2222_2222,
                      72'h33_3333_3333_3333_3333, 72'h44_4444_4444_4444_4444,
                      72'h55_5555_5555_5555_5555, 72'h66_6666_6666_6666_6666};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // Lock acquisition: four idle frames, then a data word.
        idle(4);
        check("lock_after4_pre", 72'(locked), 72'(0));
        word = 72'h12_3456_789A_BCDE_F012;
        send_beat(beat0_of(word, 1'b1));
        check("lock_not_yet", 72'(locked), 72'(0));
        send_beat(beat1_of(word, ^word));
        exp_q.push_back(word);
        check("lock_rise", 72'(locked), 72'(1));
        send_beat(beat0_of('0, 1'b0));
        check("lat_cycle1", 72'(rx_valid), 72'(0));
        send_beat(beat1_of('0, 1'b0));
        check("lat_cycle2", 72'(rx_valid), 72'(1));

        send_frame(72'hFF_0000_FFFF_0000_FFFF, 1'b1, 1'b1, -1);
        idle(1);
        send_frame(72'h80_0000_0000_0000_0001, 1'b1, 1'b1, -1);
        send_frame('1, 1'b1, 1'b1, -1);

        // One-beat slip: three bad frames drop lock, four good frames regain it.
        send_beat(beat1_of('0, 1'b0));
        for (int i = 1; i <= 7; i++) begin
            send_frame(72'hAB_CDEF_0123_4567_89AB + 72'(i), 1'b1, 1'b0, -1);
            if (i == 3) check("slip_hold", 72'(locked), 72'(1));
            if (i == 4) check("slip_drop", 72'(locked), 72'(0));
        end
        send_frame(72'h0F_0F0F_0F0F_0F0F_0F0F, 1'b1, 1'b1, -1);
        check("slip_relock", 72'(locked), 72'(1));
        idle(2);

        // Overflow under backpressure.
        ready = 1'b0;
        for (int i = 0; i < 6; i++) send_frame(ovf_words[i], 1'b1, i < 4, -1);
        idle(1);
        check("ovf_set", 72'(ovf), 72'(1));
        check("ovf_full_valid", 72'(rx_valid), 72'(1));
        ready = 1'b1;
        idle(3);
        check("ovf_drained", 72'(rx_valid), 72'(0));
        check("ovf_sticky", 72'(ovf), 72'(1));
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        check("ovf_clr", 72'(ovf), 72'(0));
        check("par_clean", 72'(par_err), 72'(0));

        // Pop in the same cycle a frame is written into a full FIFO.
        ready = 1'b0;
        for (int i = 0; i < 4; i++) send_frame(72'hC0_0000_0000_0000_0000 + 72'(i), 1'b1, 1'b1, -1);
        send_frame(72'hC0_0000_0000_0000_0004, 1'b1, 1'b1, -1);
        send_beat(beat0_of('0, 1'b0));
        ready = 1'b1;
        send_beat(beat1_of('0, 1'b0));
        ready = 1'b0;
        check("popfull_no_ovf", 72'(ovf), 72'(0));
        send_frame(72'hC0_0000_0000_0000_0005, 1'b1, 1'b0, -1);
        idle(1);
        check("popfull_still_full", 72'(ovf), 72'(1));
        ready = 1'b1;
        idle(3);
        check("popfull_drained", 72'(rx_valid), 72'(0));
        clr = 1'b1;
        idle(1);
        clr = 1'b0;

        // Parity error on payload bit 5.
        send_frame(72'h5A_A55A_A55A_A55A_A55A, 1'b1, !PAR_EN, 5);
        idle(1);
        check("par_err", 72'(par_err), 72'(PAR_EN));
        check("par_lock_kept", 72'(locked), 72'(1));
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        check("par_clr", 72'(par_err), 72'(0));

        // Reset mid-frame with two words buffered.
        ready = 1'b0;
        send_frame(72'hDE_AD00_0000_0000_0001, 1'b1, 1'b0, -1);
        send_frame(72'hDE_AD00_0000_0000_0002, 1'b1, 1'b0, -1);
        send_beat(beat0_of(72'hDE_AD00_0000_0000_0003, 1'b1));
        check("pre_rst_valid", 72'(rx_valid), 72'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("midrst");
        ready = 1'b1;
        send_frame(72'hBE_EF00_0000_0000_0001, 1'b1, 1'b0, -1);
        idle(3);
        check("midrst_hunting", 72'(locked), 72'(0));
        send_frame(72'h3C_3C3C_3C3C_3C3C_3C3C, 1'b1, 1'b1, -1);
        check("midrst_relock", 72'(locked), 72'(1));
        idle(2);
        check("sb_drained", 72'(exp_q.size()), 72'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
